// File: rtl/axi4_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// axi4_lite_master_ctrl : single-outstanding AXI4-Lite master sequencer.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module axi4_lite_master_ctrl #(
    parameter int          ADDR_W = 32,
    parameter int          DATA_W = 32,
    parameter logic [2:0]  PROT   = 3'b000
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_W-1:0]     cmd_addr,
    input  logic [DATA_W-1:0]     cmd_wdata,
    input  logic [DATA_W/8-1:0]   cmd_wstrb,

    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic [1:0]            rsp_resp,

    output logic [ADDR_W-1:0]     awaddr,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,

    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,

    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready,

    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,

    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR      = 3'd1,
        S_WR_RESP = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_DATA = 3'd4,
        S_RSP     = 3'd5
    } state_t;

    state_t state;
    state_t state_nxt;

    logic cmd_accept;
    logic aw_fin;
    logic w_fin;

    // cmd_ready is gated by reset so that every output reads 0 while held in reset.
    assign cmd_ready  = reset && (state == S_IDLE);
    assign cmd_accept = cmd_valid && cmd_ready;
    assign bready     = (state == S_WR_RESP);
    assign rready     = (state == S_RD_DATA);
    assign rsp_valid  = (state == S_RSP);
    assign awprot     = PROT;
    assign arprot     = PROT;

    // A channel is finished once its valid has dropped, or it handshakes now.
    assign aw_fin = !awvalid || awready;
    assign w_fin  = !wvalid  || wready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (cmd_accept) begin
                    state_nxt = cmd_write ? S_WR : S_RD_ADDR;
                end
            end
            S_WR: begin
                if (aw_fin && w_fin) begin
                    state_nxt = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    state_nxt = S_RSP;
                end
            end
            S_RD_ADDR: begin
                if (arready) begin
                    state_nxt = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                if (rvalid) begin
                    state_nxt = S_RSP;
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            araddr    <= '0;
            arvalid   <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= 2'b00;
        end else begin
            if (cmd_accept) begin
                if (cmd_write) begin
                    awaddr  <= cmd_addr;
                    wdata   <= cmd_wdata;
                    wstrb   <= cmd_wstrb;
                    awvalid <= 1'b1;
                    wvalid  <= 1'b1;
                end else begin
                    araddr  <= cmd_addr;
                    arvalid <= 1'b1;
                end
            end

            if (awvalid && awready) begin
                awvalid <= 1'b0;
            end
            if (wvalid && wready) begin
                wvalid <= 1'b0;
            end
            if (arvalid && arready) begin
                arvalid <= 1'b0;
            end

            if ((state == S_WR_RESP) && bvalid) begin
                rsp_rdata <= '0;
                rsp_resp  <= bresp;
            end
            if ((state == S_RD_DATA) && rvalid) begin
                rsp_rdata <= rdata;
                rsp_resp  <= rresp;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axi4_lite_master_ctrl.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_master_ctrl : scoreboard bench with a small AXI4-Lite register slave.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_axi4_lite_master_ctrl;

    logic        clk;
    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [3:0]  wstrb;
    logic [1:0]  bresp, rresp;

    axi4_lite_master_ctrl #(.ADDR_W(32), .DATA_W(32), .PROT(3'b000)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: 8 word registers at 0x00..0x1C, SLVERR beyond.
    typedef struct {
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;
    exp_t        q[$];
    logic [31:0] mmem[8];

    function automatic logic [31:0] oob_data(input logic [31:0] a);
        return 32'hBAD0_0000 | {16'h0000, a[15:0]};
    endfunction

    task automatic model_push(input bit wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        exp_t e;
        int   idx;
        idx = int'(a[4:2]);
        if (wr) begin
            e.rdata = 32'h0;
            if (a < 32) begin
                for (int b = 0; b < 4; b++)
                    if (s[b]) mmem[idx][8*b +: 8] = d[8*b +: 8];
                e.resp = 2'b00;
            end else begin
                e.resp = 2'b10;
            end
        end else begin
            if (a < 32) begin
                e.rdata = mmem[idx];
                e.resp  = 2'b00;
            end else begin
                e.rdata = oob_data(a);
                e.resp  = 2'b10;
            end
        end
        q.push_back(e);
    endtask

    // Bench AXI4-Lite slave, evaluated on falling edges.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    bit          rnd_dly = 0;
    int          aw_c, w_c, ar_c, b_c, r_c;
    bit          aw_l, w_l, ar_l, b_seen, r_seen;
    logic [31:0] la_aw, la_w, la_ar;
    logic [3:0]  la_s;
    logic [31:0] smem[8];

    initial forever begin
        @(negedge clk);
        if (!reset) begin
            awready = 0; wready = 0; arready = 0;
            bvalid = 0; rvalid = 0; bresp = 2'b00; rresp = 2'b00; rdata = 32'h0;
            aw_l = 0; w_l = 0; ar_l = 0; b_seen = 0; r_seen = 0;
            aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            for (int i = 0; i < 8; i++) smem[i] = 32'h0;
        end else begin
            if (b_seen) begin
                bvalid = 0; aw_l = 0; w_l = 0;
            end else if (aw_l && w_l && !bvalid) begin
                if (b_c >= b_dly) begin
                    if (la_aw < 32) begin
                        for (int b = 0; b < 4; b++)
                            if (la_s[b]) smem[la_aw[4:2]][8*b +: 8] = la_w[8*b +: 8];
                        bresp = 2'b00;
                    end else begin
                        bresp = 2'b10;
                    end
                    bvalid = 1; b_c = 0;
                    if (rnd_dly) b_dly = $urandom_range(0, 3);
                end else b_c++;
            end
            if (r_seen) begin
                rvalid = 0; ar_l = 0;
            end else if (ar_l && !rvalid) begin
                if (r_c >= r_dly) begin
                    rdata  = (la_ar < 32) ? smem[la_ar[4:2]] : oob_data(la_ar);
                    rresp  = (la_ar < 32) ? 2'b00 : 2'b10;
                    rvalid = 1; r_c = 0;
                    if (rnd_dly) r_dly = $urandom_range(0, 3);
                end else r_c++;
            end
            awready = 0; wready = 0; arready = 0;
            if (awvalid && !aw_l) begin
                if (aw_c >= aw_dly) begin
                    awready = 1; aw_l = 1; la_aw = awaddr; aw_c = 0;
                    if (rnd_dly) aw_dly = $urandom_range(0, 3);
                end else aw_c++;
            end
            if (wvalid && !w_l) begin
                if (w_c >= w_dly) begin
                    wready = 1; w_l = 1; la_w = wdata; la_s = wstrb; w_c = 0;
                    if (rnd_dly) w_dly = $urandom_range(0, 3);
                end else w_c++;
            end
            if (arvalid && !ar_l) begin
                if (ar_c >= ar_dly) begin
                    arready = 1; ar_l = 1; la_ar = araddr; ar_c = 0;
                    if (rnd_dly) ar_dly = $urandom_range(0, 3);
                end else ar_c++;
            end
            b_seen = bvalid && bready;
            r_seen = rvalid && rready;
        end
    end

    // Response-side ready: 0 = always, 1 = held low, 2 = random.
    int rsp_mode = 0;
    initial forever begin
        @(negedge clk);
        case (rsp_mode)
            0:       rsp_ready = 1'b1;
            1:       rsp_ready = 1'b0;
            default: rsp_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: traces, handshake-stability checks and scoreboard pops.
    int          tr_aw, tr_w, tr_ar, tr_aw_first, tr_b_first, tr_rsp_first, rsp_hs_cyc;
    bit          pv_aw, pv_w, pv_ar, pv_rsp;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rdata;
    logic [3:0]  p_wstrb;
    logic [1:0]  p_resp;

    task automatic clear_trace();
        tr_aw = 0; tr_w = 0; tr_ar = 0;
        tr_aw_first = -1; tr_b_first = -1; tr_rsp_first = -1;
    endtask

    initial forever begin
        @(negedge clk);
        #1;
        if (!reset) begin
            pv_aw = 0; pv_w = 0; pv_ar = 0; pv_rsp = 0;
        end else begin
            if (awvalid) begin
                tr_aw++;
                if (tr_aw_first < 0) tr_aw_first = cyc;
            end
            if (wvalid) tr_w++;
            if (arvalid) tr_ar++;
            if (bready && tr_b_first < 0) tr_b_first = cyc;
            if (rsp_valid && tr_rsp_first < 0) tr_rsp_first = cyc;

            if (pv_aw) check("aw_hold", {31'h0, awvalid, awaddr}, {31'h0, 1'b1, p_awaddr});
            if (pv_w)  check("w_hold", {27'h0, wvalid, wstrb, wdata}, {27'h0, 1'b1, p_wstrb, p_wdata});
            if (pv_ar) check("ar_hold", {31'h0, arvalid, araddr}, {31'h0, 1'b1, p_araddr});
            if (pv_rsp) check("rsp_hold", {29'h0, rsp_valid, rsp_resp, rsp_rdata}, {29'h0, 1'b1, p_resp, p_rdata});
            if (rsp_valid) check("cmd_ready_during_rsp", 64'(cmd_ready), 64'd0);

            if (rsp_valid && rsp_ready) begin
                if (q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
                    check("rsp_resp", 64'(rsp_resp), 64'(e.resp));
                end
                rsp_hs_cyc = cyc;
            end

            pv_aw = awvalid && !awready; p_awaddr = awaddr;
            pv_w  = wvalid && !wready;   p_wdata = wdata; p_wstrb = wstrb;
            pv_ar = arvalid && !arready; p_araddr = araddr;
            pv_rsp = rsp_valid && !rsp_ready; p_rdata = rsp_rdata; p_resp = rsp_resp;
        end
    end

    task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, output int acc);
        int n;
        @(negedge clk);
        cmd_valid = 1; cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        model_push(wr, a, d, s);
        n = 0;
        while (!cmd_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_timeout", 64'(cmd_ready), 64'd1);
        acc = cyc;
        if (cmd_ready) begin
            @(posedge clk);
            #1;
        end
        cmd_valid = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("rsp_drain_timeout", 64'(q.size()), 64'd0);
        q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string pfx);
        check({pfx, "_ctl"}, {55'h0, cmd_ready, awvalid, wvalid, arvalid, bready, rready, rsp_valid, rsp_resp == 2'b00}, {55'h0, 9'h001});
        check({pfx, "_prot"}, {58'h0, awprot, arprot}, 64'd0);
        check({pfx, "_addr"}, {awaddr, araddr}, 64'd0);
        check({pfx, "_wdata"}, {28'h0, wstrb, wdata}, 64'd0);
        check({pfx, "_rsp_rdata"}, 64'(rsp_rdata), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    int acc, acc2, n;

    initial begin
        reset = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
        for (int i = 0; i < 8; i++) mmem[i] = 32'h0;
        clear_trace();
        rsp_hs_cyc = -1;
        repeat (3) @(negedge clk);
        #1;
        check_outputs_zero("reset");
        #1 reset = 1;
        @(negedge clk); #1;
        check("cmd_ready_after_reset", 64'(cmd_ready), 64'd1);

        // Best-case write then read back.
        clear_trace();
        issue(1, 32'h0, 32'h1234_5678, 4'hF, acc);
        wait_idle();
        check("wr_aw_cycles", 64'(tr_aw), 64'd1);
        check("wr_w_cycles", 64'(tr_w), 64'd1);
        check("wr_aw_start", 64'(tr_aw_first - acc), 64'd1);
        check("wr_bready_cyc", 64'(tr_b_first - acc), 64'd2);
        check("wr_rsp_cyc", 64'(tr_rsp_first - acc), 64'd3);

        clear_trace();
        issue(0, 32'h0, 32'hFFFF_FFFF, 4'h0, acc);
        wait_idle();
        check("rd_ar_cycles", 64'(tr_ar), 64'd1);
        check("rd_rsp_cyc", 64'(tr_rsp_first - acc), 64'd3);

        // Delayed awready.
        clear_trace();
        aw_dly = 3;
        issue(1, 32'h4, 32'hA5A5_0F0F, 4'b0101, acc);
        wait_idle();
        aw_dly = 0;
        check("awdly_aw_cycles", 64'(tr_aw), 64'd4);
        check("awdly_w_cycles", 64'(tr_w), 64'd1);
        check("awdly_bready_cyc", 64'(tr_b_first - acc), 64'd5);
        issue(0, 32'h4, 32'h0, 4'h0, acc);
        wait_idle();

        // Out-of-range address.
        issue(1, 32'd50, 32'hCAFE_BABE, 4'hF, acc);
        issue(0, 32'd50, 32'h0, 4'h0, acc);
        wait_idle();

        // Response held off; next command waits for the response handshake.
        clear_trace();
        rsp_mode = 1;
        issue(1, 32'h8, 32'h0BAD_F00D, 4'b1100, acc);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        check("hold_rsp_seen", 64'(rsp_valid), 64'd1);
        fork
            issue(0, 32'h8, 32'h0, 4'h0, acc2);
            begin
                repeat (5) @(negedge clk);
                rsp_mode = 0;
            end
        join
        check("b2b_accept_cyc", 64'(acc2 - rsp_hs_cyc), 64'd1);
        check("hold_len_ge5", 64'(rsp_hs_cyc - tr_rsp_first >= 5), 64'd1);
        wait_idle();

        // Reset while in WR_RESP with bvalid asserted.
        b_dly = 2;
        issue(1, 32'hC, 32'h1111_2222, 4'hF, acc);
        n = 0;
        bvalid = bvalid;
        while (n < 100) begin
            @(negedge clk); #2;
            if (bvalid) break;
            n++;
        end
        check("rst_bvalid_pending", {62'h0, bvalid, bready}, 64'd3);
        reset = 0;
        #1;
        check_outputs_zero("midreset");
        q.delete();
        for (int i = 0; i < 8; i++) mmem[i] = 32'h0;
        repeat (2) @(negedge clk);
        #2 reset = 1;
        b_dly = 0;
        @(negedge clk); #1;
        check("cmd_ready_after_midreset", 64'(cmd_ready), 64'd1);
        issue(1, 32'h10, 32'hDEAD_BEEF, 4'hF, acc);
        issue(0, 32'h10, 32'h0, 4'h0, acc);
        issue(0, 32'h0, 32'h0, 4'h0, acc);
        wait_idle();

        // Randomized traffic.
        rnd_dly = 1;
        rsp_mode = 2;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(8, 40) * 4) : 32'($urandom_range(0, 7) * 4);
            issue(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), acc);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
